// File: rtl/hexdisp_pkg.sv
// Shared types and the seven-segment glyph table for the hex display engine.
// Segments are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package hexdisp_pkg;

    typedef logic [3:0] hex_digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // 0-9, A, b, C, d, E, F
    localparam seg_t GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-digit to active-low segment decoder; hidden digits go blank.
module seven_seg_decode
    import hexdisp_pkg::*;
(
    input  hex_digit_t digit,
    input  logic       visible,
    output seg_t       seg
);

    always_comb begin
        seg = visible ? GLYPH_TABLE[digit] : SEG_BLANK;
    end

endmodule

// File: rtl/hex_display_buffer.sv
// Registered multi-digit seven-segment engine with addressed writes, shift-in and blanking.
// Define HEXDISP_BLINK_EN to build the blink prescaler and honour blink_mask.
module hex_display_buffer
    import hexdisp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ADDR_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [3:0]              wr_data,
    input  logic                    shift_en,
    input  logic [3:0]              shift_data,
    input  logic [NUM_DIGITS-1:0]   turn_on,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    wr_drop,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    logic [4*NUM_DIGITS-1:0] store_reg;
    logic [4*NUM_DIGITS-1:0] store_next;
    logic [7*NUM_DIGITS-1:0] hex_out_reg;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic                    wr_drop_reg;
    logic                    wr_drop_next;
    logic                    wr_accept;
    logic                    wr_in_range;
    logic [NUM_DIGITS-1:0]   visible;
    logic [2**ADDR_W-1:0]    addr_valid;

    // Addresses past the last digit exist only when NUM_DIGITS is not a power of two.
    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_addr_valid
        assign addr_valid[gi] = (gi < NUM_DIGITS);
    end

    assign wr_in_range  = addr_valid[wr_addr];
    assign wr_accept    = wr_en && !shift_en && wr_in_range;
    assign wr_drop_next = wr_en && !wr_accept;

`ifdef HEXDISP_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] blink_cnt_reg;
    logic [CNT_W-1:0] blink_cnt_next;
    logic             blink_phase_reg;
    logic             blink_phase_next;

    always_comb begin
        blink_cnt_next   = blink_cnt_reg + CNT_W'(1);
        blink_phase_next = blink_phase_reg;
        if (blink_cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    assign visible = turn_on & ~(blink_mask & {NUM_DIGITS{blink_phase_reg}});
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
    assign visible      = turn_on;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        hex_digit_t shift_src;

        // Digit 0 takes the shift-in value; every other digit takes its right neighbour.
        if (gi == 0) begin : g_lsd
            assign shift_src = shift_data;
        end else begin : g_upper
            assign shift_src = store_reg[4*(gi-1) +: 4];
        end

        assign store_next[4*gi +: 4] =
            shift_en                                   ? shift_src :
            (wr_accept && (wr_addr == ADDR_W'(gi)))    ? wr_data   :
                                                         store_reg[4*gi +: 4];

        seven_seg_decode u_decode (
            .digit   (store_reg[4*gi +: 4]),
            .visible (visible[gi]),
            .seg     (seg_next[7*gi +: 7])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            store_reg   <= '0;
            hex_out_reg <= '1;
            wr_drop_reg <= 1'b0;
        end else begin
            store_reg   <= store_next;
            hex_out_reg <= seg_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    assign hex_out = hex_out_reg;
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_hex_display_buffer.sv
// Directed bench for hex_display_buffer with a per-cycle expectation scoreboard.
module tb_hex_display_buffer;

    localparam int N  = 8;
    localparam int BD = 4;
    localparam int AW = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [3:0]     wr_data;
    logic           shift_en;
    logic [3:0]     shift_data;
    logic [N-1:0]   turn_on;
    logic [N-1:0]   blink_mask;
    logic           wr_drop;
    logic [7*N-1:0] hex_out;

    hex_display_buffer #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .turn_on    (turn_on),
        .blink_mask (blink_mask),
        .wr_drop    (wr_drop),
        .hex_out    (hex_out)
    );

    always #5 clock = ~clock;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7*N-1:0] hex;
        logic           drop;
    } exp_t;

    exp_t       sb [$];
    logic [3:0] m_dig [N];
    int         m_cnt;
    logic       m_phase;
    int         tests = 0;
    int         fails = 0;
    int         blank_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7*N-1:0] predict();
        logic [7*N-1:0] h;
        logic           vis;
        for (int i = 0; i < N; i++) begin
`ifdef HEXDISP_BLINK_EN
            vis = turn_on[i] && !(blink_mask[i] && m_phase);
`else
            vis = turn_on[i];
`endif
            h[7*i +: 7] = vis ? glyph[m_dig[i]] : 7'h7F;
        end
        return h;
    endfunction

    // Push what the DUT must show after the coming edge, advance the model, then pop and compare.
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        if (reset) begin
            e.hex  = '1;
            e.drop = 1'b0;
        end else begin
            e.hex  = predict();
            e.drop = wr_en && (shift_en || (int'(wr_addr) >= N));
        end
        sb.push_back(e);
        if (reset) begin
            for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
            m_cnt   = 0;
            m_phase = 1'b0;
        end else begin
            if (shift_en) begin
                for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = shift_data;
            end else if (wr_en && int'(wr_addr) < N) begin
                m_dig[wr_addr] = wr_data;
            end
`ifdef HEXDISP_BLINK_EN
            if (m_cnt == BD - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
`endif
        end
        @(posedge clock);
        #1;
        got = sb.pop_front();
        check({tag, " hex_out"}, 64'(hex_out), 64'(got.hex));
        check({tag, " wr_drop"}, 64'(wr_drop), 64'(got.drop));
    endtask

    task automatic do_write(input int addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick("write");
        wr_en   = 1'b0;
    endtask

    task automatic do_shift(input logic [3:0] data);
        shift_en   = 1'b1;
        shift_data = data;
        tick("shift");
        shift_en   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        shift_en   = 1'b0;
        shift_data = '0;
        turn_on    = 8'hFF;
        blink_mask = 8'h00;
        for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
        m_cnt   = 0;
        m_phase = 1'b0;

        tick("reset");
        tick("reset");
        check("reset blank", 64'(hex_out), 64'(56'hFF_FFFF_FFFF_FFFF));
        check("reset drop", 64'(wr_drop), 64'd0);
        reset = 1'b0;
        tick("release");
        check("zero glyphs", 64'(hex_out), 64'({8{7'h40}}));

        do_write(3, 4'hA);
        tick("idle");
        check("digit3 A", 64'(hex_out), 64'({{4{7'h40}}, 7'h08, {3{7'h40}}}));

        do_shift(4'h1);
        do_shift(4'h2);
        do_shift(4'h3);
        tick("idle");
        check("shift 123", 64'(hex_out[20:0]), 64'({7'h79, 7'h24, 7'h30}));

        for (int i = 0; i < N; i++) do_shift(4'h0);
        tick("idle");
        check("flush", 64'(hex_out), 64'({8{7'h40}}));

        wr_en      = 1'b1;
        wr_addr    = 3'd5;
        wr_data    = 4'h7;
        shift_en   = 1'b1;
        shift_data = 4'h9;
        tick("collide");
        check("drop pulse", 64'(wr_drop), 64'd1);
        wr_en    = 1'b0;
        shift_en = 1'b0;
        tick("idle");
        check("drop end", 64'(wr_drop), 64'd0);
        check("shift won d0", 64'(hex_out[6:0]), 64'(7'h10));
        check("write lost d5", 64'(hex_out[41:35]), 64'(7'h40));

        for (int v = 0; v < 16; v++) do_write(v % N, 4'(v));
        tick("idle");
        check("glyph sweep", 64'(hex_out),
              64'({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}));

        // Blink: digit 0 masked, others steady; then restart via reset mid-blink.
        reset = 1'b1;
        tick("reset");
        reset      = 1'b0;
        blink_mask = 8'h01;
        blank_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            tick("blink");
            if (hex_out[6:0] === 7'h7F) blank_cnt++;
        end
`ifdef HEXDISP_BLINK_EN
        check("blink count", 64'(blank_cnt), 64'd8);
`else
        check("blink count", 64'(blank_cnt), 64'd0);
`endif
        for (int i = 0; i < 6; i++) tick("blink");
        reset = 1'b1;
        tick("mid reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick("blink restart");
`ifdef HEXDISP_BLINK_EN
        check("restart phase", 64'(hex_out[6:0]), 64'(7'h7F));
`else
        check("restart phase", 64'(hex_out[6:0]), 64'(7'h40));
`endif
        check("restart steady", 64'(hex_out[55:7]), 64'({7{7'h40}}));
        for (int i = 0; i < 6; i++) tick("blink restart");

        blink_mask = 8'h00;
        turn_on    = 8'hFE;
        tick("turn_on");
        check("d0 off", 64'(hex_out[6:0]), 64'(7'h7F));
        turn_on = 8'hFF;
        tick("turn_on");
        check("d0 on", 64'(hex_out[6:0]), 64'(7'h40));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_display_buffer.md
# hex_display_buffer

Parametrised, registered seven-segment display engine for the DE2 board. It holds one 4-bit hex value per digit. Digits are loaded by addressed writes or by shifting in from the right. Each digit can be blanked or made to blink. The block drives active-low segment outputs for any number of digits. It replaces combinational switch-to-HEX wiring in chip-level interfaces and gives game logic (scores, lives, level) a persistent display it can update one digit at a time.

## Interface
- NUM_DIGITS, default 8: number of displayed digits, 1..16.
- BLINK_DIV, default 25_000_000: clock cycles per blink half-period, ≥2.
- ADDR_W, default $clog2(NUM_DIGITS) (min 1): digit address width. Derived; not overridden.
- clock  in  1: system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1: synchronous, active-high.
- wr_en  in  1: write strobe.
- wr_addr  in  ADDR_W: digit index, 0 = rightmost.
- wr_data  in  4: hex value to write.
- shift_en  in  1: shift all digits left by one and insert shift_data at digit 0.
- shift_data  in  4: value inserted on a shift.
- turn_on  in  NUM_DIGITS: per-digit enable. 0 blanks the digit.
- blink_mask  in  NUM_DIGITS: per-digit blink select.
- wr_drop  out  1: one-cycle pulse when a write is discarded.
- hex_out  out  7*NUM_DIGITS: active-low segments. Digit i occupies [7i+6:7i], bit order g..a.

## Operation
- Digit store: NUM_DIGITS × 4-bit registers, all 0 after reset.
- Priority each cycle: reset > shift_en > wr_en.
- Shift: digit[i] ← digit[i-1] for i>0; digit[0] ← shift_data. Digit NUM_DIGITS-1 is discarded.
- Write: digit[wr_addr] ← wr_data.
- A write is dropped when shift_en is high in the same cycle, or when wr_addr ≥ NUM_DIGITS. A dropped write leaves the store unchanged and pulses wr_drop in the next cycle.
- Blink prescaler: counter runs 0..BLINK_DIV-1 and wraps to 0. blink_phase toggles on each wrap. Reset sets counter = 0 and blink_phase = 0.
- Visibility: a digit is visible when turn_on[i] && !(blink_mask[i] && blink_phase).
- Output: a visible digit shows the standard hex glyph 0–F (b and d lowercase). A hidden digit shows 7'h7F.
- turn_on and blink_mask are sampled every cycle and are not latched.

## Timing
- Reset values: hex_out = all ones (every digit blank), wr_drop = 0.
- Write or shift on edge k updates the store at k. hex_out reflects the new value after edge k+1, giving 1-cycle output latency.
- A turn_on or blink_mask change is visible on hex_out one edge later.
- blink_phase first goes 1 at edge BLINK_DIV after reset release. Blinking digits are hidden while blink_phase = 1.
- Back-to-back writes or shifts are accepted every cycle. There is no busy state.
- Reset asserted mid-operation clears the store, counter, phase and outputs at the next edge. Inputs in that cycle are ignored.

## Configuration
- HEXDISP_BLINK_EN defined: prescaler, blink_phase and blink_mask behave as above.
- HEXDISP_BLINK_EN undefined: no prescaler logic. blink_phase is constant 0, blink_mask is ignored, and visibility = turn_on[i]. The port list is unchanged.

## Structure
- Package hexdisp_pkg holds:
  - typedef `hex_digit_t` (logic [3:0]);
  - typedef `seg_t` (logic [6:0], active-low);
  - constant `SEG_BLANK` = 7'h7F;
  - the 16-entry glyph constant table.
- One sub-module, seven_seg_decode: purely combinational `hex_digit_t` + visible → `seg_t`. It is instantiated NUM_DIGITS times in a generate loop. The output register lives in the parent.

## Test plan
NUM_DIGITS=8, BLINK_DIV=4, turn_on=8'hFF unless stated.
- Reset, then idle one cycle → hex_out = 56'hFF_FFFF_FFFF_FFFF during reset. Every digit shows glyph 0 (7'h40) once reset is released.
- Write addr 3 = 4'hA at edge k → digit 3 = 7'h08 after edge k+1. Other digits are unchanged.
- Shift in 1, 2, 3 on consecutive cycles → digits 2,1,0 = 1,2,3. A further 8 shifts of 0 flush every digit to 0.
- wr_en and shift_en together with wr_addr=5, wr_data=7, shift_data=9 → shift applied (digit0=9), digit 5 is not 7, and wr_drop is high for exactly one cycle.
- blink_mask=8'h01 → digit 0 alternates visible/blank every 4 cycles, and digits 1–7 stay steady. Rebuild without HEXDISP_BLINK_EN → digit 0 stays steady.
- turn_on=8'hFE → digit 0 = 7'h7F one edge after the change. Asserting reset mid-blink → counter and phase restart from 0.
